// File: rtl/mem_bus_adapter_if.sv
// ---------------------------------------------------------------------------
// mem_bus_adapter_if
//
// Data-memory bus between the adapter (master) and the memory (slave).
//
// Handshake: the master raises bus_req together with bus_addr/bus_be/bus_we/
// bus_wdata and holds all of them stable until it samples bus_ack high on a
// rising edge. That edge completes the beat, and bus_rdata is valid in the
// same cycle as bus_ack. The master may drop bus_req without an ack (reset or
// timeout), so the slave must tolerate an abandoned beat.
//
// Signals:
//   bus_req   master->slave  beat request
//   bus_we    master->slave  1 = write
//   bus_addr  master->slave  word-aligned address ([1:0] always 0)
//   bus_be    master->slave  byte enables
//   bus_wdata master->slave  lane-positioned write data
//   bus_rdata slave->master  read data, valid with bus_ack
//   bus_ack   slave->master  beat complete
// ---------------------------------------------------------------------------
interface mem_bus_adapter_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/mem_bus_adapter.sv
// ---------------------------------------------------------------------------
// mem_bus_adapter
//
// Turns one load/store request from the load/store controller (byte address,
// size 1/2/4 bytes, right-aligned write data) into one or two word-aligned bus
// beats with byte enables, and returns right-aligned, zero-filled load data.
// The pipeline is stalled while the access is in flight.
//
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   load, store   request strobes, held by the pipeline while stall=1
//   xfer_size     transfer size in bytes (1, 2 or 4; others are rejected)
//   addr          byte address
//   wr_data       store data, right-aligned
//   rd_data       load result; holds until the next completed load
//   stall         pipeline hold (combinational)
//   done          one-cycle completion pulse
//   err           one-cycle pulse replacing done on reject/timeout
//   bus           memory bus, master side (see mem_bus_adapter_if)
//   dbg_state_o   current FSM state (0 IDLE, 1 BEAT0, 2 BEAT1, 3 FIN)
// ---------------------------------------------------------------------------
module mem_bus_adapter #(
  parameter int          ALLOW_MISALIGNED = 1,
  parameter int unsigned ACK_TIMEOUT      = 0,
  parameter int unsigned TO_W             = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic                     store,
  input  logic [2:0]               xfer_size,
  input  logic [31:0]              addr,
  input  logic [31:0]              wr_data,
  output logic [31:0]              rd_data,
  output logic                     stall,
  output logic                     done,
  output logic                     err,
  mem_bus_adapter_if.master        bus,
  output logic [1:0]               dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  localparam bit             TO_EN   = (ACK_TIMEOUT > 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_EN ? ACK_TIMEOUT - 1 : 0);

  state_t            state_q;
  logic              is_load_q;
  logic [1:0]        off_q;
  logic [31:0]       mask_q;
  logic              cross_q;
  logic [3:0]        be_hi_q;
  logic [31:0]       wdata_hi_q;
  logic [31:0]       r0_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic [31:0]       rd_data_q;
  logic              done_q;
  logic              err_q;
  logic              bus_req_q;
  logic              bus_we_q;
  logic [31:0]       bus_addr_q;
  logic [3:0]        bus_be_q;
  logic [31:0]       bus_wdata_q;

  // ---------------- request decode (IDLE side) ----------------
  logic [1:0]  req_off;
  logic        size_ok;
  logic [3:0]  size_mask;
  logic [31:0] byte_mask;
  logic [3:0]  end_off;
  logic        crosses;
  logic        reject;
  logic [7:0]  be_span;
  logic [63:0] wd_span;

  assign req_off = addr[1:0];

  always_comb begin
    size_ok   = 1'b1;
    size_mask = 4'b0000;
    byte_mask = 32'h0000_0000;
    case (xfer_size)
      3'd1: begin size_mask = 4'b0001; byte_mask = 32'h0000_00FF; end
      3'd2: begin size_mask = 4'b0011; byte_mask = 32'h0000_FFFF; end
      3'd4: begin size_mask = 4'b1111; byte_mask = 32'hFFFF_FFFF; end
      default: size_ok = 1'b0;
    endcase
  end

  assign end_off = {2'b00, req_off} + {1'b0, xfer_size};
  assign crosses = (end_off > 4'd4);
  assign reject  = (load && store) || !size_ok || (crosses && (ALLOW_MISALIGNED == 0));

  // Both beats' enables and data come from one 8-lane span: the low half is
  // beat 0, the spilled high half is beat 1.
  assign be_span = {4'b0000, size_mask} << req_off;
  assign wd_span = {32'h0000_0000, wr_data} << {req_off, 3'b000};

  // ---------------- read assembly (at FIN entry) ----------------
  logic [31:0] beat_lo;
  logic [31:0] beat_hi;
  logic [63:0] rd_span;
  logic [31:0] rd_assembled;

  always_comb begin
    if (state_q == S_BEAT1) begin
      beat_lo = r0_q;
      beat_hi = bus.bus_rdata;
    end else begin
      beat_lo = bus.bus_rdata;
      beat_hi = 32'h0000_0000;
    end
    rd_span      = {beat_hi, beat_lo} >> {off_q, 3'b000};
    rd_assembled = rd_span[31:0] & mask_q;
  end

  // Ack has priority over the timeout in the same cycle.
  logic timed_out;
  assign timed_out = TO_EN && !bus.bus_ack && (to_cnt_q == TO_LAST);

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      is_load_q   <= 1'b0;
      off_q       <= 2'b00;
      mask_q      <= 32'h0000_0000;
      cross_q     <= 1'b0;
      be_hi_q     <= 4'b0000;
      wdata_hi_q  <= 32'h0000_0000;
      r0_q        <= 32'h0000_0000;
      to_cnt_q    <= '0;
      rd_data_q   <= 32'h0000_0000;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0000_0000;
      bus_be_q    <= 4'b0000;
      bus_wdata_q <= 32'h0000_0000;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (load || store) begin
            if (reject) begin
              err_q   <= 1'b1;
              state_q <= S_FIN;
            end else begin
              is_load_q   <= load;
              off_q       <= req_off;
              mask_q      <= byte_mask;
              cross_q     <= crosses;
              be_hi_q     <= be_span[7:4];
              wdata_hi_q  <= wd_span[63:32];
              bus_req_q   <= 1'b1;
              bus_we_q    <= store;
              bus_addr_q  <= {addr[31:2], 2'b00};
              bus_be_q    <= be_span[3:0];
              bus_wdata_q <= wd_span[31:0];
              to_cnt_q    <= '0;
              state_q     <= S_BEAT0;
            end
          end
        end

        S_BEAT0, S_BEAT1: begin
          if (bus.bus_ack) begin
            if ((state_q == S_BEAT0) && cross_q) begin
              if (is_load_q) r0_q <= bus.bus_rdata;
              // Address wraps naturally past 0xFFFF_FFFC.
              bus_addr_q  <= bus_addr_q + 32'd4;
              bus_be_q    <= be_hi_q;
              bus_wdata_q <= wdata_hi_q;
              to_cnt_q    <= '0;
              state_q     <= S_BEAT1;
            end else begin
              bus_req_q <= 1'b0;
              done_q    <= 1'b1;
              if (is_load_q) rd_data_q <= rd_assembled;
              state_q   <= S_FIN;
            end
          end else if (timed_out) begin
            bus_req_q <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= S_FIN;
          end else if (TO_EN) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end

        // Requests seen here are ignored; the next one is taken in IDLE.
        S_FIN: state_q <= S_IDLE;

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stall = ((state_q == S_IDLE) && (load || store)) ||
                 (state_q == S_BEAT0) || (state_q == S_BEAT1);

  assign rd_data       = rd_data_q;
  assign done          = done_q;
  assign err           = err_q;
  assign dbg_state_o   = state_q;
  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_be    = bus_be_q;
  assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_bus_adapter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_adapter
//
// dut  : ALLOW_MISALIGNED=1, ACK_TIMEOUT=4, driven by a waiting bus model.
// dut2 : ALLOW_MISALIGNED=0, ACK_TIMEOUT=0, slow fixed-latency bus model.
// Expected beats and results come from a byte-lane model of the access.
// ---------------------------------------------------------------------------
module tb_mem_bus_adapter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  logic        load = 1'b0, store = 1'b0;
  logic [2:0]  xfer_size = 3'd4;
  logic [31:0] addr = 32'h0, wr_data = 32'h0;
  logic [31:0] rd_data;
  logic        stall, done, err;
  logic [1:0]  dbg_state;

  logic        load2 = 1'b0, store2 = 1'b0;
  logic [31:0] rd_data2;
  logic        stall2, done2, err2;
  logic [1:0]  dbg_state2;

  mem_bus_adapter_if bus();
  mem_bus_adapter_if bus2();

  mem_bus_adapter #(.ALLOW_MISALIGNED(1), .ACK_TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .reset(reset), .load(load), .store(store), .xfer_size(xfer_size),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .stall(stall), .done(done),
    .err(err), .bus(bus), .dbg_state_o(dbg_state)
  );

  mem_bus_adapter #(.ALLOW_MISALIGNED(0), .ACK_TIMEOUT(0), .TO_W(8)) dut2 (
    .clk(clk), .reset(reset), .load(load2), .store(store2), .xfer_size(xfer_size),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data2), .stall(stall2), .done(done2),
    .err(err2), .bus(bus2), .dbg_state_o(dbg_state2)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [68:0] exp_beat_q[$];   // {addr, be, we, wdata}
  logic [31:0] rdata_q[$];      // data returned per acked beat
  logic [32:0] exp_q[$];        // {err, rd_data}
  logic [31:0] rd_model = 32'h0;

  // ---------------- bus model for dut ----------------
  int          cur_wait = 0;
  int          wait_cnt = 0;
  int          req_cycles = 0;
  bit          in_beat = 1'b0;
  logic [68:0] beat_hold;

  initial begin
    bus.bus_ack = 1'b0;
    bus.bus_rdata = 32'h0;
  end

  always @(negedge clk) begin
    if (bus.bus_req) begin
      req_cycles++;
      if (in_beat)
        check("beat_stable", {bus.bus_addr, bus.bus_be, bus.bus_we, bus.bus_wdata}, beat_hold);
      else begin
        beat_hold = {bus.bus_addr, bus.bus_be, bus.bus_we, bus.bus_wdata};
        in_beat = 1'b1;
      end
      if (wait_cnt >= cur_wait) begin
        bus.bus_ack = 1'b1;
        if (rdata_q.size() != 0) bus.bus_rdata = rdata_q.pop_front();
        else bus.bus_rdata = $urandom();
        check("beat_pending", 32'(exp_beat_q.size() != 0), 1);
        if (exp_beat_q.size() != 0) check("beat", beat_hold, exp_beat_q.pop_front());
        wait_cnt = 0;
        in_beat = 1'b0;
      end else begin
        bus.bus_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      bus.bus_ack = 1'b0;
      wait_cnt = 0;
      in_beat = 1'b0;
    end
  end

  // ---------------- bus model for dut2: ack on the 7th request cycle ----------------
  int wait2 = 0;
  int req2_cycles = 0;

  initial begin
    bus2.bus_ack = 1'b0;
    bus2.bus_rdata = 32'h0;
  end

  always @(negedge clk) begin
    if (bus2.bus_req) begin
      req2_cycles++;
      if (wait2 >= 6) begin
        bus2.bus_ack = 1'b1;
        bus2.bus_rdata = 32'hCAFE_F00D;
        wait2 = 0;
      end else begin
        bus2.bus_ack = 1'b0;
        wait2++;
      end
    end else begin
      bus2.bus_ack = 1'b0;
      wait2 = 0;
    end
  end

  // ---------------- byte-lane reference model ----------------
  task automatic model(input bit ld, input bit st, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] r0, input logic [31:0] r1, input bit allow,
                       output bit rej, output bit crs,
                       output logic [31:0] ad0, output logic [31:0] ad1,
                       output logic [3:0] be0, output logic [3:0] be1,
                       output logic [31:0] wd0, output logic [31:0] wd1,
                       output logic [31:0] rd);
    rej = (ld && st) || !(sz == 3'd1 || sz == 3'd2 || sz == 3'd4);
    ad0 = {a[31:2], 2'b00};
    ad1 = ad0 + 32'd4;
    crs = 1'b0;
    be0 = 4'b0; be1 = 4'b0; wd0 = 32'h0; wd1 = 32'h0; rd = 32'h0;
    if (!rej) begin
      for (int i = 0; i < 4; i++) begin
        logic [31:0] ba;
        int lane;
        ba = a + 32'(i);
        lane = int'(ba[1:0]);
        if (ba[31:2] == a[31:2]) begin
          wd0[8*lane +: 8] = wd[8*i +: 8];
          if (i < int'(sz)) begin
            be0[lane] = 1'b1;
            rd[8*i +: 8] = r0[8*lane +: 8];
          end
        end else begin
          wd1[8*lane +: 8] = wd[8*i +: 8];
          if (i < int'(sz)) begin
            crs = 1'b1;
            be1[lane] = 1'b1;
            rd[8*i +: 8] = r1[8*lane +: 8];
          end
        end
      end
      if (crs && !allow) rej = 1'b1;
    end
  endtask

  // ---------------- driver for dut ----------------
  task automatic access(input bit ld, input bit st, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd, input int wt,
                        input logic [31:0] r0, input logic [31:0] r1);
    bit rej, crs, to_exp, exp_err, fin;
    logic [31:0] ad0, ad1, wd0, wd1, rd_new;
    logic [3:0] be0, be1;
    logic [32:0] exp_res;
    int nb, lat, cyc;
    model(ld, st, sz, a, wd, r0, r1, 1'b1, rej, crs, ad0, ad1, be0, be1, wd0, wd1, rd_new);
    nb = rej ? 0 : (crs ? 2 : 1);
    to_exp = !rej && (wt >= 4);
    exp_err = rej || to_exp;
    if (!exp_err) begin
      exp_beat_q.push_back({ad0, be0, st, wd0});
      rdata_q.push_back(r0);
      if (crs) begin
        exp_beat_q.push_back({ad1, be1, st, wd1});
        rdata_q.push_back(r1);
      end
      if (ld) rd_model = rd_new;
    end
    exp_q.push_back({exp_err, rd_model});
    lat = rej ? 1 : (to_exp ? 5 : nb * (wt + 1) + 1);

    cur_wait = wt;
    req_cycles = 0;
    load = ld; store = st; xfer_size = sz; addr = a; wr_data = wd;
    #1;
    check("stall_req", stall, 1);
    cyc = 0;
    fin = 1'b0;
    while (!fin && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done || err) fin = 1'b1;
      else check("stall_busy", stall, 1);
    end
    check("completion", fin, 1);
    if (fin) begin
      check("done_err_excl", done && err, 0);
      check("stall_fin", stall, 0);
      check("state_fin", dbg_state, 2'd3);
      check("result_pending", 32'(exp_q.size()), 1);
      if (exp_q.size() != 0) begin
        exp_res = exp_q.pop_front();
        check("result", {err, rd_data}, exp_res);
        check("done", done, !exp_res[32]);
      end
      check("latency", cyc, lat);
      check("req_cycles", req_cycles, to_exp ? 4 : nb * (wt + 1));
    end
    check("beats_consumed", 32'(exp_beat_q.size()), 0);
    exp_beat_q.delete();
    rdata_q.delete();
    exp_q.delete();
    load = 1'b0; store = 1'b0;
    @(negedge clk);
    check("pulse_end", {done, err}, 2'b00);
  endtask

  // ---------------- driver for dut2 (4-byte accesses) ----------------
  task automatic access2(input bit st, input logic [31:0] a, input bit exp_err,
                         input logic [31:0] exp_rd, input int exp_req, input int exp_lat);
    bit fin;
    int cyc;
    req2_cycles = 0;
    load2 = !st; store2 = st; xfer_size = 3'd4; addr = a; wr_data = 32'h1234_5678;
    cyc = 0;
    fin = 1'b0;
    while (!fin && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done2 || err2) fin = 1'b1;
    end
    check("d2_completion", fin, 1);
    check("d2_err", err2, exp_err);
    check("d2_done", done2, !exp_err);
    check("d2_rd", rd_data2, exp_rd);
    check("d2_req_cycles", req2_cycles, exp_req);
    check("d2_latency", cyc, exp_lat);
    load2 = 1'b0; store2 = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit rej, crs, fin;
    logic [31:0] ad0, ad1, wd0, wd1, rd_new;
    logic [3:0] be0, be1;
    logic [2:0] sz;
    bit ld;
    int cyc;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd", rd_data, 0);
    check("rst_bus", {bus.bus_req, bus.bus_we, bus.bus_addr, bus.bus_be, bus.bus_wdata}, 0);
    check("rst_flags", {done, err, stall}, 3'b000);
    check("rst_state", dbg_state, 2'd0);
    reset = 1'b0;
    @(negedge clk);

    // Aligned LW, ack one cycle after req
    access(1, 0, 3'd4, 32'h0000_0100, 32'h0, 1, 32'hDEAD_BEEF, 32'h0);
    check("lw_rd", rd_data, 32'hDEAD_BEEF);
    // SB to the top lane
    access(0, 1, 3'd1, 32'h0000_0203, 32'h0000_00A5, 0, 32'h0, 32'h0);
    // Crossing LH
    access(1, 0, 3'd2, 32'h0000_0307, 32'h0, 0, 32'h1122_3344, 32'h5566_7788);
    check("lh_rd", rd_data, 32'h0000_8811);
    // Crossing SW wrapping the address space
    access(0, 1, 3'd4, 32'hFFFF_FFFE, 32'hAABB_CCDD, 0, 32'h0, 32'h0);
    check("sw_rd_hold", rd_data, 32'h0000_8811);
    // Timeout on an LW
    access(1, 0, 3'd4, 32'h0000_0500, 32'h0, 100, 32'h0, 32'h0);
    check("to_rd_hold", rd_data, 32'h0000_8811);
    // Invalid size and load&store
    access(1, 0, 3'd3, 32'h0000_0600, 32'h0, 0, 32'h0, 32'h0);
    access(1, 1, 3'd4, 32'h0000_0600, 32'h0, 0, 32'h0, 32'h0);

    // dut2: crossing store rejected, then a slow aligned load with no timeout
    access2(1, 32'hFFFF_FFFE, 1'b1, 32'h0, 0, 1);
    access2(0, 32'h0000_0040, 1'b0, 32'hCAFE_F00D, 7, 8);

    // Random accesses
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 2))
        0: sz = 3'd1;
        1: sz = 3'd2;
        default: sz = 3'd4;
      endcase
      ld = ($urandom_range(0, 1) == 1);
      access(ld, !ld, sz, $urandom(), $urandom(), int'($urandom_range(0, 2)),
             $urandom(), $urandom());
    end

    // Reset during BEAT1 of a crossing load
    model(1, 0, 3'd4, 32'h0000_0302, 32'h0, 32'h0102_0304, 32'h0, 1'b1,
          rej, crs, ad0, ad1, be0, be1, wd0, wd1, rd_new);
    exp_beat_q.push_back({ad0, be0, 1'b0, wd0});
    rdata_q.push_back(32'h0102_0304);
    cur_wait = 2;
    load = 1'b1; store = 1'b0; xfer_size = 3'd4; addr = 32'h0000_0302; wr_data = 32'h0;
    cyc = 0;
    fin = 1'b0;
    while (!fin && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (dbg_state == 2'd2) fin = 1'b1;
    end
    check("reached_beat1", dbg_state, 2'd2);
    reset = 1'b1;
    load = 1'b0;
    @(negedge clk);
    check("mid_rst_req", bus.bus_req, 0);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_state", dbg_state, 2'd0);
    check("mid_rst_rd", rd_data, 0);
    check("mid_rst_flags", {done, err}, 2'b00);
    check("mid_rst_beats", 32'(exp_beat_q.size()), 0);
    reset = 1'b0;
    rd_model = 32'h0;
    exp_beat_q.delete();
    rdata_q.delete();
    @(negedge clk);
    access(1, 0, 3'd4, 32'h0000_0700, 32'h0, 0, 32'h7654_3210, 32'h0);
    check("post_rst_rd", rd_data, 32'h7654_3210);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
